fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in BUSY waiting for fpu_valid before error; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester command valid; bit 0 = requester 0 (core), bit 1 = requester 1 (DMA).
REQ-005 req_op1_0, req_op2_0, req_op1_1, req_op2_1  input  32 each  IEEE-754 single operands per requester.
REQ-006 req_sel_0, req_sel_1  input  3 each  opcode: 000 add, 001 sub, 010 mult; others illegal.
REQ-007 req_ready  output  2  one-hot pulse; command of that requester accepted this cycle.
REQ-008 resp_valid  output  2  one-hot, one-cycle response pulse to the owning requester.
REQ-009 resp_result  output  32  result, valid while any resp_valid bit high.
REQ-010 resp_err  output  1  error flag (illegal opcode or timeout), qualified by resp_valid.
REQ-011 fpu_op1, fpu_op2  output  32 each  operands driven to FPU.
REQ-012 fpu_sel  output  3  opcode driven to FPU.
REQ-013 fpu_enable  output  1  FPU enable.
REQ-014 fpu_result  input  32  FPU result.
REQ-015 fpu_valid  input  1  FPU data valid.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, BUSY, RESP; one command in flight at a time.
REQ-018 In IDLE, if exactly one req_valid bit is set, that requester SHALL be granted; if both, the requester not granted most recently SHALL win (round-robin).
REQ-019 Grant SHALL assert req_ready for the winner combinationally in the same IDLE cycle; operands, opcode and owner index SHALL be registered on that edge.
REQ-020 Legal opcode: next state BUSY; illegal opcode: next state RESP with resp_err=1, resp_result=0, FPU never enabled.
REQ-021 fpu_op1/fpu_op2/fpu_sel SHALL present the registered command; they hold last values outside BUSY.
REQ-022 fpu_enable SHALL be 1 only in BUSY; RESP guarantees at least one enable-low cycle between consecutive commands.
REQ-023 In BUSY a wait counter SHALL start at 0 on entry and increment each cycle fpu_valid is low.
REQ-024 fpu_valid high in BUSY: latch fpu_result, resp_err=0, go RESP; fpu_valid on the same cycle counter reaches TIMEOUT SHALL count as success.
REQ-025 Counter reaching TIMEOUT with fpu_valid low: resp_result=0, resp_err=1, go RESP.
REQ-026 fpu_valid outside BUSY SHALL be ignored.
REQ-027 RESP SHALL last exactly one cycle: resp_valid bit of owner high, last-grant pointer updated to owner, next state IDLE.
REQ-028 No req_ready SHALL assert in BUSY or RESP; requesters hold req_valid and operands until req_ready.
REQ-029 Minimum latency req accept -> resp_valid SHALL be FPU latency + 1 cycle; illegal opcode 1 cycle.

Reset
REQ-030 rst high SHALL force immediately: state IDLE, req_ready=0, resp_valid=0, resp_result=0, resp_err=0, fpu_enable=0, fpu_op1/op2=0, fpu_sel=000, busy=0, counter=0, last-grant=1 (requester 0 wins first tie).
REQ-031 rst asserted mid-BUSY SHALL abort the command with no response; after release arbitration restarts from REQ-030 values.

Verification
REQ-032 Req0 add 0x3F800000 + 0x40000000, FPU model valid after 3 cycles -> req_ready[0] one cycle, fpu_enable high 3 cycles, resp_valid=01, result 0x40400000, err 0.
REQ-033 Both request same cycle after reset, then again -> first grant req0, second req1; no overlap of fpu_enable; enable low in RESP between them.
REQ-034 Req1 sel=111 -> resp_valid=10 next cycle, err 1, result 0, fpu_enable never high.
REQ-035 FPU model never asserts valid, TIMEOUT=15 -> resp_valid after 15 BUSY cycles, err 1, result 0, then IDLE.
REQ-036 rst pulsed in 2nd BUSY cycle -> all outputs per REQ-030 immediately, no resp_valid; next request served normally.
REQ-037 fpu_valid pulsed in IDLE -> no resp_valid, state unchanged.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// Handshake bundle between two FPU requesters, the arbiter and the FPU.
// master = requesters/FPU side, slave = arbiter side.
interface fpu_arbiter_if;
    logic [1:0]  req_valid;
    logic [31:0] req_op1_0;
    logic [31:0] req_op2_0;
    logic [31:0] req_op1_1;
    logic [31:0] req_op2_1;
    logic [2:0]  req_sel_0;
    logic [2:0]  req_sel_1;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_result;
    logic        resp_err;
    logic [31:0] fpu_op1;
    logic [31:0] fpu_op2;
    logic [2:0]  fpu_sel;
    logic        fpu_enable;
    logic [31:0] fpu_result;
    logic        fpu_valid;
    logic        busy;

    modport master (
        output req_valid, req_op1_0, req_op2_0,
        output req_op1_1, req_op2_1,
        output req_sel_0, req_sel_1,
        input  req_ready, resp_valid,
        input  resp_result, resp_err,
        input  fpu_op1, fpu_op2, fpu_sel, fpu_enable,
        output fpu_result, fpu_valid,
        input  busy
    );

    modport slave (
        input  req_valid, req_op1_0, req_op2_0,
        input  req_op1_1, req_op2_1,
        input  req_sel_0, req_sel_1,
        output req_ready, resp_valid,
        output resp_result, resp_err,
        output fpu_op1, fpu_op2, fpu_sel, fpu_enable,
        input  fpu_result, fpu_valid,
        output busy
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between core (0) and DMA (1),
// one command in flight, with illegal-opcode and timeout error responses.
module fpu_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic        clk,
    input logic        rst,
    fpu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] op1_q, op2_q, res_q;
    logic [2:0]  sel_q;
    logic [7:0]  cnt_q;
    logic        owner_q, err_q, last_q;

    logic        win;
    logic [1:0]  grant;
    logic [2:0]  win_sel;
    logic        illegal;
    logic        tmo_hit;

    always_comb begin
        win = 1'b0;
        case (bus.req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    // Grant is combinational, suppressed while reset is held
    assign grant = (state_q == IDLE && !rst && |bus.req_valid)
                   ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign win_sel = win ? bus.req_sel_1 : bus.req_sel_0;
    assign illegal = win_sel > 3'd2;
    assign tmo_hit = !bus.fpu_valid && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|grant) state_d = illegal ? RESP : BUSY;
            BUSY: if (bus.fpu_valid || tmo_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = grant;
        bus.resp_valid  = 2'b00;
        bus.resp_result = 32'd0;
        bus.resp_err    = 1'b0;
        bus.fpu_enable  = 1'b0;
        bus.busy        = state_q != IDLE;
        bus.fpu_op1     = op1_q;
        bus.fpu_op2     = op2_q;
        bus.fpu_sel     = sel_q;
        case (state_q)
            BUSY: bus.fpu_enable = 1'b1;
            RESP: begin
                bus.resp_valid  = owner_q ? 2'b10 : 2'b01;
                bus.resp_result = res_q;
                bus.resp_err    = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            sel_q   <= 3'd0;
            owner_q <= 1'b0;
            cnt_q   <= 8'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else if (|grant) begin
            op1_q   <= win ? bus.req_op1_1 : bus.req_op1_0;
            op2_q   <= win ? bus.req_op2_1 : bus.req_op2_0;
            sel_q   <= win_sel;
            owner_q <= win;
            cnt_q   <= 8'd0;
            res_q   <= 32'd0;
            err_q   <= illegal;
        end else if (state_q == BUSY) begin
            // A late fpu_valid on the timeout cycle still wins
            if (bus.fpu_valid) begin
                res_q <= bus.fpu_result;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
                if (tmo_hit) begin
                    res_q <= 32'd0;
                    err_q <= 1'b1;
                end
            end
        end else if (state_q == RESP) begin
            last_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a fixed-latency FPU model.
// Expected values are hand-computed per scenario.
module tb_fpu_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    int          fpu_lat;
    logic [31:0] fpu_res_val;
    logic        force_v;
    int          en_cnt = 0;

    fpu_arbiter_if bus ();

    fpu_arbiter #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.fpu_enable) en_cnt <= en_cnt + 1;
        else                en_cnt <= 0;
    end

    assign bus.fpu_valid = force_v |
        (bus.fpu_enable && fpu_lat != 0 && en_cnt == fpu_lat - 1);
    assign bus.fpu_result = bus.fpu_valid ? fpu_res_val : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic set0(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s);
        bus.req_op1_0 = a;
        bus.req_op2_0 = b;
        bus.req_sel_0 = s;
    endtask

    task automatic set1(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] s);
        bus.req_op1_1 = a;
        bus.req_op2_1 = b;
        bus.req_sel_1 = s;
    endtask

    // Runs from the accept edge until a response shows up (bounded)
    task automatic wait_resp(input logic [1:0] clr,
                             output int ena, output int lat,
                             output logic [1:0] rv,
                             output logic [31:0] rr, output logic re,
                             output logic rdy_seen, output logic en_resp,
                             output logic [31:0] op1_1st,
                             output logic [2:0] sel_1st);
        ena = 0; lat = 0; rv = 2'b00; rr = 32'd0; re = 1'b0;
        rdy_seen = 1'b0; en_resp = 1'b0;
        op1_1st = 32'd0; sel_1st = 3'd0;
        for (int i = 0; i < 40; i++) begin
            next();
            if (i == 0) bus.req_valid = bus.req_valid & ~clr;
            #1;
            lat++;
            if (i == 0) begin
                op1_1st = bus.fpu_op1;
                sel_1st = bus.fpu_sel;
            end
            if (bus.req_ready != 2'b00) rdy_seen = 1'b1;
            if (bus.fpu_enable) ena++;
            if (bus.resp_valid != 2'b00) begin
                rv = bus.resp_valid;
                rr = bus.resp_result;
                re = bus.resp_err;
                en_resp = bus.fpu_enable;
                break;
            end
        end
    endtask

    initial begin
        int          ena, lat;
        logic [1:0]  rv;
        logic [31:0] rr, op1f;
        logic        re, rdy, enr, seen;
        logic [2:0]  self;

        rst = 1'b1;
        force_v = 1'b0;
        fpu_lat = 3;
        fpu_res_val = 32'h40400000;
        bus.req_valid = 2'b00;
        set0(32'd0, 32'd0, 3'd0);
        set1(32'd0, 32'd0, 3'd0);
        next();
        next();
        bus.req_valid = 2'b01;
        #1;
        chk("rst_rdy", bus.req_ready, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_en", bus.fpu_enable, 1'b0);
        chk("rst_rv", bus.resp_valid, 2'b00);
        chk("rst_rr", bus.resp_result, 32'd0);
        chk("rst_err", bus.resp_err, 1'b0);
        chk("rst_op1", bus.fpu_op1, 32'd0);
        chk("rst_op2", bus.fpu_op2, 32'd0);
        chk("rst_sel", bus.fpu_sel, 3'd0);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        next();

        // 1.0 + 2.0 from the core
        set0(32'h3F800000, 32'h40000000, 3'd0);
        bus.req_valid = 2'b01;
        #1;
        chk("add_rdy", bus.req_ready, 2'b01);
        wait_resp(2'b01, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("add_op1", op1f, 32'h3F800000);
        chk("add_lat", lat, 4);
        chk("add_ena", ena, 3);
        chk("add_rv", rv, 2'b01);
        chk("add_rr", rr, 32'h40400000);
        chk("add_err", re, 1'b0);
        chk("add_rdyq", rdy, 1'b0);
        next();
        #1;
        chk("add_idle", bus.busy, 1'b0);
        chk("add_rvlo", bus.resp_valid, 2'b00);

        // Tie right after reset: core then DMA
        rst = 1'b1;
        next();
        rst = 1'b0;
        next();
        fpu_res_val = 32'h40800000;
        set0(32'h40000000, 32'h40000000, 3'd0);
        set1(32'h40A00000, 32'h3F800000, 3'd1);
        bus.req_valid = 2'b11;
        #1;
        chk("tie_rdy0", bus.req_ready, 2'b01);
        wait_resp(2'b01, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("tie_rv0", rv, 2'b01);
        chk("tie_rr0", rr, 32'h40800000);
        chk("tie_enresp", enr, 1'b0);
        chk("tie_rdyq", rdy, 1'b0);
        next();
        #1;
        chk("tie_rdy1", bus.req_ready, 2'b10);
        chk("tie_enidle", bus.fpu_enable, 1'b0);
        wait_resp(2'b10, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("tie_op1", op1f, 32'h40A00000);
        chk("tie_sel", self, 3'd1);
        chk("tie_rv1", rv, 2'b10);
        chk("tie_ena1", ena, 3);

        // Illegal opcode from DMA
        next();
        set1(32'h12345678, 32'h9ABCDEF0, 3'b111);
        bus.req_valid = 2'b10;
        #1;
        chk("ill_rdy", bus.req_ready, 2'b10);
        wait_resp(2'b10, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("ill_lat", lat, 1);
        chk("ill_rv", rv, 2'b10);
        chk("ill_err", re, 1'b1);
        chk("ill_rr", rr, 32'd0);
        chk("ill_ena", ena, 0);

        // FPU never answers
        next();
        fpu_lat = 0;
        set0(32'h3F800000, 32'h3F800000, 3'd0);
        bus.req_valid = 2'b01;
        #1;
        wait_resp(2'b01, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("tmo_lat", lat, 16);
        chk("tmo_ena", ena, 15);
        chk("tmo_rv", rv, 2'b01);
        chk("tmo_err", re, 1'b1);
        chk("tmo_rr", rr, 32'd0);
        next();
        #1;
        chk("tmo_idle", bus.busy, 1'b0);

        // Valid arrives on the last allowed cycle
        next();
        fpu_lat = 15;
        fpu_res_val = 32'h41200000;
        bus.req_valid = 2'b01;
        #1;
        wait_resp(2'b01, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        chk("edge_lat", lat, 16);
        chk("edge_err", re, 1'b0);
        chk("edge_rr", rr, 32'h41200000);

        // Reset during the second BUSY cycle
        next();
        fpu_lat = 5;
        set0(32'h40400000, 32'h40000000, 3'd2);
        bus.req_valid = 2'b01;
        #1;
        next();
        bus.req_valid = 2'b00;
        #1;
        chk("mid_sel", bus.fpu_sel, 3'd2);
        next();
        rst = 1'b1;
        #1;
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_en", bus.fpu_enable, 1'b0);
        chk("mid_op1", bus.fpu_op1, 32'd0);
        chk("mid_sel0", bus.fpu_sel, 3'd0);
        chk("mid_rv", bus.resp_valid, 2'b00);
        next();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next();
            if (bus.resp_valid != 2'b00) seen = 1'b1;
        end
        chk("mid_noresp", seen, 1'b0);
        fpu_lat = 3;
        fpu_res_val = 32'h40C00000;
        bus.req_valid = 2'b11;
        #1;
        chk("mid_tie", bus.req_ready, 2'b01);
        wait_resp(2'b01, ena, lat, rv, rr, re, rdy, enr, op1f, self);
        bus.req_valid = 2'b00;
        chk("mid_lat", lat, 4);
        chk("mid_rr", rr, 32'h40C00000);

        // Stray fpu_valid while idle
        next();
        next();
        force_v = 1'b1;
        #1;
        chk("stray_rv", bus.resp_valid, 2'b00);
        next();
        force_v = 1'b0;
        #1;
        chk("stray_busy", bus.busy, 1'b0);
        chk("stray_rv2", bus.resp_valid, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
